// File: rtl/shift_sequencer.sv
//------------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle controller that feeds the barrel shifter for data-processing
// instructions. Immediate-shift and no-shift instructions make a single
// shifter pass. Register-shifted-register instructions first win the shared
// RF read port, capture Rs[7:0] as the shift amount, and then run the shifter.
// The shifter result and carry-out are registered and handed to the ALU
// stage through a valid/ready handshake.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start/start_ready decode handshake; accepted when both are high
//   instr, rm_data    instruction word and Rm operand
//   carry_in          current C flag
//   rs_req/rs_gnt     shared RF read port request / grant
//   rs_addr, rs_data  Rs index (valid with rs_req) / Rs value (cycle after grant)
//   sh_*              latched operands presented to the shifter
//   sh_result/sh_flag combinational shifter outputs
//   res_valid/ready   result handshake towards the ALU stage
//   shift_result/flag registered shifter outputs
//   err               one-cycle pulse when the RF port grant times out
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module shift_sequencer #(
  parameter int MAX_WAIT   = 4,
  parameter int WAIT_CNT_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        start_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rm_data,
  input  logic        carry_in,
  output logic        rs_req,
  output logic [3:0]  rs_addr,
  input  logic        rs_gnt,
  input  logic [31:0] rs_data,
  output logic [31:0] sh_rd2,
  output logic [4:0]  sh_control,
  output logic [7:0]  sh_instr,
  output logic [7:0]  sh_rd3,
  output logic        sh_carry,
  input  logic [31:0] sh_result,
  input  logic        sh_flag,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] shift_result,
  output logic        shift_flag,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_RS  = 3'd1,
    CAPT_RS = 3'd2,
    SHIFT   = 3'd3,
    RESULT  = 3'd4
  } state_t;

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [3:0]            rs_addr_q, rs_addr_d;
  logic [31:0]           rd2_q, rd2_d;
  logic [4:0]            control_q, control_d;
  logic [7:0]            sinstr_q, sinstr_d;
  logic [7:0]            rd3_q, rd3_d;
  logic                  carry_q, carry_d;
  logic [31:0]           result_q, result_d;
  logic                  flag_q, flag_d;

  logic accept;
  logic reg_shift;
  logic unused_bits;

  // Only the fields the shifter and the Rs fetch need are consumed.
  assign unused_bits = ^{instr[31:28], instr[3:0], rs_data[31:8]};

  assign start_ready = (state_q == IDLE) | ((state_q == RESULT) & res_ready);
  assign accept      = start & start_ready;
  assign reg_shift   = (instr[27:25] == 3'b000) & ~instr[7] & instr[4];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    rs_addr_d = rs_addr_q;
    rd2_d     = rd2_q;
    control_d = control_q;
    sinstr_d  = sinstr_q;
    rd3_d     = rd3_q;
    carry_d   = carry_q;
    result_d  = result_q;
    flag_d    = flag_q;

    unique case (state_q)
      IDLE: ;
      REQ_RS: begin
        if (rs_gnt) begin
          state_d = CAPT_RS;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CAPT_RS: begin
        // rs_data is valid the cycle after the grant.
        rd3_d   = rs_data[7:0];
        state_d = SHIFT;
      end
      SHIFT: begin
        result_d = sh_result;
        flag_d   = sh_flag;
        state_d  = RESULT;
      end
      RESULT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new instruction can only be accepted from IDLE or from RESULT while
    // the ALU stage takes the current result; it overrides the case above.
    if (accept) begin
      rs_addr_d = instr[11:8];
      rd2_d     = rm_data;
      control_d = instr[25:21];
      sinstr_d  = instr[11:4];
      rd3_d     = 8'h00;
      carry_d   = carry_in;
      cnt_d     = '0;
      state_d   = reg_shift ? REQ_RS : SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rs_addr_q <= '0;
      rd2_q     <= '0;
      control_q <= '0;
      sinstr_q  <= '0;
      rd3_q     <= '0;
      carry_q   <= 1'b0;
      result_q  <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rs_addr_q <= rs_addr_d;
      rd2_q     <= rd2_d;
      control_q <= control_d;
      sinstr_q  <= sinstr_d;
      rd3_q     <= rd3_d;
      carry_q   <= carry_d;
      result_q  <= result_d;
      flag_q    <= flag_d;
    end
  end

  assign rs_req       = (state_q == REQ_RS);
  assign res_valid    = (state_q == RESULT);
  assign err          = err_q;
  assign rs_addr      = rs_addr_q;
  assign sh_rd2       = rd2_q;
  assign sh_control   = control_q;
  assign sh_instr     = sinstr_q;
  assign sh_rd3       = rd3_q;
  assign sh_carry     = carry_q;
  assign shift_result = result_q;
  assign shift_flag   = flag_q;

endmodule

// File: tb/tb_shift_sequencer.sv
`timescale 1ns/1ps
module tb_shift_sequencer;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_ready;
  logic [31:0] instr = '0;
  logic [31:0] rm_data = '0;
  logic        carry_in = 1'b0;
  logic        rs_req;
  logic [3:0]  rs_addr;
  logic        rs_gnt = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] sh_rd2;
  logic [4:0]  sh_control;
  logic [7:0]  sh_instr;
  logic [7:0]  sh_rd3;
  logic        sh_carry;
  logic [31:0] sh_result;
  logic        sh_flag;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] shift_result;
  logic        shift_flag;
  logic        err;

  always #5 clk = ~clk;

  shift_sequencer #(.MAX_WAIT(MAX_WAIT), .WAIT_CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
    .instr(instr), .rm_data(rm_data), .carry_in(carry_in),
    .rs_req(rs_req), .rs_addr(rs_addr), .rs_gnt(rs_gnt), .rs_data(rs_data),
    .sh_rd2(sh_rd2), .sh_control(sh_control), .sh_instr(sh_instr),
    .sh_rd3(sh_rd3), .sh_carry(sh_carry), .sh_result(sh_result),
    .sh_flag(sh_flag), .res_valid(res_valid), .res_ready(res_ready),
    .shift_result(shift_result), .shift_flag(shift_flag), .err(err)
  );

  // ARM-style barrel shifter: returns {carry_out, result}.
  function automatic logic [32:0] shmodel(input logic [31:0] v, input logic [1:0] typ,
                                          input logic [7:0] amt, input logic c);
    logic [63:0]        x;
    logic signed [63:0] sx;
    logic [31:0]        r;
    int                 n;
    if (amt == 8'd0) return {c, v};
    case (typ)
      2'd0: begin x = {32'b0, v} << amt; return {x[32], x[31:0]}; end
      2'd1: begin x = {v, 32'b0} >> amt; return {x[31], x[63:32]}; end
      2'd2: begin sx = $signed({v, 32'b0}) >>> amt; return {sx[31], sx[63:32]}; end
      default: begin
        n = int'(amt[4:0]);
        r = (n == 0) ? v : ((v >> n) | (v << (32 - n)));
        return {r[31], r};
      end
    endcase
  endfunction

  always_comb begin
    {sh_flag, sh_result} = shmodel(sh_rd2, sh_instr[2:1],
                                   sh_instr[0] ? sh_rd3 : {3'b000, sh_instr[7:3]}, sh_carry);
  end

  typedef struct {
    bit          is_err;
    logic [31:0] res;
    logic        flg;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   seen_first = 0;

  // Plan for the transaction currently using the RF port.
  int          plan_wait = 0;
  int          plan_len = 0;
  logic [31:0] plan_rs = '0;
  logic [3:0]  plan_addr = '0;
  bit          force_gnt = 0;
  int          rr_mode = 0;
  bit          last_rv = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result acceptance from the ALU side.
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = ($urandom_range(0, 2) != 0);
      default: res_ready = 1'b0;
    endcase
  end

  // RF port arbiter model: grants after plan_wait refused cycles, data the cycle after.
  int run = 0;
  int cur_exp = 0;
  always @(negedge clk) begin
    rs_data = rs_gnt ? plan_rs : $urandom;
    if (rs_req) begin
      if (run == 0) cur_exp = plan_len;
      check("rs_addr", 64'(rs_addr), 64'(plan_addr));
      rs_gnt = force_gnt || (run == plan_wait);
      run++;
    end else begin
      if (run != 0) begin
        check("rs_req_len", 64'(run), 64'(cur_exp));
        run = 0;
      end
      rs_gnt = force_gnt;
    end
  end

  // Monitor: compares every presented result/err against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (err) begin
        if (q.size() == 0 || !q[0].is_err) check("err_unexpected", 64'(err), 64'(0));
        else begin
          check("err_cycle", 64'(cyc), 64'(q[0].cyc));
          void'(q.pop_front());
        end
      end
      if (res_valid) begin
        if (q.size() == 0 || q[0].is_err) begin
          check("res_unexpected", 64'(res_valid), 64'(0));
          if (q.size() != 0 && res_ready) void'(q.pop_front());
        end else begin
          if (!seen_first) begin
            check("latency", 64'(cyc), 64'(q[0].cyc));
            seen_first = 1;
          end
          check("shift_result", 64'(shift_result), 64'(q[0].res));
          check("shift_flag", 64'(shift_flag), 64'(q[0].flg));
          if (res_ready) begin
            void'(q.pop_front());
            seen_first = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] rm, input logic c,
                       input logic [31:0] rsd, input int w, input bit junk, input int idle);
    int          n;
    exp_t        e;
    bit          regp;
    logic [7:0]  amt;
    logic [32:0] m;
    n = 0;
    repeat (idle) begin @(negedge clk); start = 1'b0; end
    @(negedge clk);
    while (!start_ready && n < 300) begin
      start = junk;
      if (junk) begin instr = $urandom; rm_data = $urandom; carry_in = 1'($urandom); end
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      check("accept_timeout", 64'(start_ready), 64'(1));
      start = 1'b0;
      return;
    end
    last_rv  = res_valid;
    start    = 1'b1;
    instr    = ins;
    rm_data  = rm;
    carry_in = c;
    plan_rs  = rsd;
    plan_wait = w;
    plan_addr = ins[11:8];
    regp = (ins[27:25] == 3'b000) && !ins[7] && ins[4];
    if (regp && w >= MAX_WAIT) begin
      e.is_err = 1; e.res = '0; e.flg = 1'b0; e.cyc = cyc + 1 + MAX_WAIT;
      plan_len = MAX_WAIT;
    end else begin
      amt = !ins[4] ? {3'b000, ins[11:7]} : (regp ? rsd[7:0] : 8'h00);
      m = shmodel(rm, ins[6:5], amt, c);
      e.is_err = 0; e.res = m[31:0]; e.flg = m[32];
      e.cyc = regp ? cyc + 4 + w : cyc + 2;
      plan_len = regp ? w + 1 : 0;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || res_valid || rs_req || err) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("drain_timeout", 64'(q.size()), 64'(0));
    @(negedge clk);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_ctl"}, 64'({start_ready, rs_req, res_valid, err, rs_addr,
                              sh_control, sh_carry, shift_flag}), 64'(15'h4000));
    check({pfx, "_lat"}, 64'({sh_rd2, sh_instr, sh_rd3}), 64'(0));
    check({pfx, "_res"}, 64'(shift_result), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, rsd;
    int          w;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Immediate shift: MOV R0,R1,LSL#4.
    issue(32'hE1A00201, 32'h000000F1, 1'b1, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("t1_sh_control", 64'(sh_control), 64'(5'h0D));
    check("t1_sh_instr", 64'(sh_instr), 64'(8'h20));
    check("t1_sh_rd2", 64'(sh_rd2), 64'(32'hF1));
    check("t1_sh_carry", 64'(sh_carry), 64'(1));
    drain();

    // Register shift, grant in first request cycle.
    issue(32'hE1A00231, 32'h80000000, 1'b0, 32'h00000104, 0, 0, 0);
    drain();
    check("t2_sh_rd3", 64'(sh_rd3), 64'(8'h04));
    check("t2_rs_addr", 64'(rs_addr), 64'(4'h2));

    // Grant in third request cycle.
    issue(32'hE1A00231, 32'h80000000, 1'b0, 32'h00000104, 2, 0, 0);
    drain();

    // Grant timeout, then a fresh instruction.
    issue(32'hE1A00231, 32'h80000000, 1'b0, 32'h00000104, MAX_WAIT, 0, 0);
    drain();
    issue(32'hE1A00201, 32'h000000F1, 1'b1, 32'h0, 0, 0, 0);
    drain();

    // Backpressure, then back-to-back accept.
    rr_mode = 2;
    issue(32'hE1A00461, 32'h8000000F, 1'b0, 32'h0, 0, 0, 0);
    repeat (8) @(negedge clk);
    check("bp_res_valid", 64'(res_valid), 64'(1));
    rr_mode = 0;
    issue(32'hE1A00141, 32'h12345678, 1'b1, 32'h0, 0, 0, 0);
    check("b2b_accept_in_result", 64'(last_rv), 64'(1));
    drain();

    // Reset while waiting for the RF port; a stale grant afterwards is ignored.
    @(negedge clk);
    start = 1'b1; instr = 32'hE1A00331; rm_data = 32'hDEADBEEF; carry_in = 1'b1;
    plan_wait = 99; plan_len = 2; plan_addr = 4'h3; plan_rs = 32'h000000AA;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    reset = 1'b0;
    q.delete();
    seen_first = 0;
    force_gnt = 1;
    repeat (2) @(negedge clk);
    force_gnt = 0;
    @(negedge clk);
    check_zero("rst_stale");
    @(negedge clk);
    check_zero("rst_stale2");

    // Randomized traffic with backpressure and ignored starts.
    rr_mode = 1;
    for (int i = 0; i < 80; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) begin ins[27:25] = 3'b000; ins[7] = 1'b0; ins[4] = 1'b1; end
      rsd = $urandom;
      if ($urandom_range(0, 1) == 1) rsd[7:0] = 8'($urandom_range(0, 40));
      w = $urandom_range(0, MAX_WAIT);
      issue(ins, $urandom, 1'($urandom), rsd, w, 1'($urandom), $urandom_range(0, 2));
    end
    drain();
    rr_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
